counter_updown_param: RTL
=========================

# counter_updown_param

Parametrised up/down counter with selectable bound behaviour: wrap, saturate, one-shot and bounce. It also has a programmable step, runtime min/max bounds and a built-in prescaler. It is the general-purpose successor to the lab 4-bit up/down counter and serves as the timing and sequence source for lab peripherals (PWM bases, LED sequencers, timeouts).

## Interface
- `WIDTH`, default 8: counter, bound, step and load width.
- `PRESCALE_W`, default 8: prescaler compare width.

- `iClk` input 1: single clock; all state updates on its rising edge.
- `iReset` input 1: reset, synchronous, active-high.
- `iEnable` input 1: enables the prescaler and counting.
- `iClear` input 1: loads `iInitialValue`, restarts the prescaler and clears `oDone`.
- `iUp_down` input 1: 1 = count up, 0 = count down. In bounce mode it is sampled only on `iClear`.
- `iMode` input 2: 00 wrap, 01 saturate, 10 one-shot, 11 bounce.
- `iStep` input WIDTH: magnitude added or subtracted per tick.
- `iMin`, `iMax` input WIDTH: inclusive bounds, unsigned.
- `iInitialValue` input WIDTH: load value.
- `iPrescale` input PRESCALE_W: a tick occurs every `iPrescale`+1 enabled cycles.
- `oData` output WIDTH: count, registered.
- `oDir` output 1: effective direction, registered.
- `oWrap` output 1: one-cycle pulse whenever the bound rule fires, registered.
- `oDone` output 1: sticky one-shot completion, registered.
- `oAtMax`, `oAtMin` output 1: combinational, `oData == iMax` / `oData == iMin`.

## Operation
- Priority per edge: `iReset` > `iClear` > tick.
- **Reset:** `oData`=0, `oDir`=1, `oWrap`=0, `oDone`=0, prescaler=0.
- **Clear:**
  - `oData`=`iInitialValue`, loaded unclamped.
  - `oDir`=`iUp_down`, prescaler=0, `oDone`=0, `oWrap`=0.
- **Prescaler:**
  - Increments on each `iEnable` cycle and holds when `iEnable`=0.
  - Tick = `iEnable` && prescaler == `iPrescale`; the prescaler returns to 0 on a tick.
  - `iPrescale`=0 gives a tick on every enabled cycle.
- **Direction:** `d` = `oDir` in bounce mode, `iUp_down` otherwise. In non-bounce modes `oDir` follows `iUp_down` every cycle.
- **Arithmetic:** computed in WIDTH+1 bits with no truncation.
  - Up: cand = `oData`+`iStep`; the bound rule fires if cand > `iMax`.
  - Down: the bound rule fires if `oData` < `iMin`+`iStep`, i.e. cand would fall below `iMin`. This is evaluated in WIDTH+1 bits, so there is no underflow alias.
  - Otherwise `oData` <= cand.
- **Bound rule** (with bound = `iMax` going up, `iMin` going down):
  - Wrap: `oData` <= opposite bound; the remainder is discarded.
  - Saturate: `oData` <= bound.
  - One-shot: `oData` <= bound, `oDone` <= 1. While `oDone`=1, ticks are ignored until clear or reset.
  - Bounce: `oData` <= bound, `oDir` <= ~`oDir`.
  - In all modes `oWrap` <= 1 for that cycle. This includes repeated clamped ticks in saturate mode.
- `iStep`=0: `oData` is unchanged; the bound rule can fire only if `oData` is already outside the bounds.
- `iMin` > `iMax`: ticks do not change `oData`, `oDir` or `oDone`, and `oWrap` stays 0. Clear and reset still apply.
- Bounds, step and mode are sampled live on each tick. Changing them mid-count takes effect on the next tick.

## Timing
- One-cycle latency: a tick, clear or reset at edge N is visible on `oData`/`oDir`/`oDone` after edge N.
- `oWrap` is high for exactly the one cycle following the firing edge, aligned with the updated `oData`.
- `oAtMax`/`oAtMin` update combinationally from `oData` and the live bounds.
- Reset or clear during a prescaler phase discards the partial phase. The first tick after release occurs `iPrescale`+1 enabled cycles later.
- Clear and tick in the same cycle: clear wins and no step is applied.

## Test plan
- **Reset mid-count:** WIDTH=8, counting up at 37, assert `iReset` 1 cycle -> next cycle `oData`=0, `oDir`=1, `oDone`=0, `oWrap`=0. With `iPrescale`=3, the first increment comes 4 enabled cycles after release.
- **Wrap up:** min=10, max=20, step=3, `iPrescale`=0, mode 00, load 18, enable up -> `oData` 18, 10 (`oWrap` pulses 1 cycle), 13, 16, 19, 10 (`oWrap`).
- **Saturate down:** min=10, max=200, step=5, load 12, down -> 10 with `oAtMin`=1, then holds at 10 with `oWrap` high on every following tick. Then `iUp_down`=1 -> 15.
- **Prescaler and enable gating:** `iPrescale`=3, step 1, up from 0 -> increments on cycles 4, 8, 12. Drop `iEnable` for 2 cycles after cycle 9 -> the next increment moves from cycle 12 to cycle 14.
- **One-shot with WIDTH+1 compare:** min=0, max=255, step=4, mode 10, load 250 up -> 254, then 255 with `oDone`=1 (254+4=258 is detected, no alias to 2). Further ticks hold 255. `iClear` with 100 -> `oData`=100, `oDone`=0.
- **Bounce:** min=0, max=5, step=2, mode 11, clear with `iUp_down`=1 and value 4 -> 5 (`oDir`=0, `oWrap`), 3, 1, 0 (`oDir`=1, `oWrap`), 2. Clear and tick in the same cycle -> load only.

Source files
------------

// File: rtl/counter_updown_param.sv
// Up/down counter with prescaler, runtime bounds, programmable step and wrap/saturate/one-shot/bounce bound rules.
// One-cycle update latency on tick/clear/reset; oAtMax/oAtMin are combinational from oData and the live bounds.
module counter_updown_param #(
    parameter int WIDTH      = 8,
    parameter int PRESCALE_W = 8
) (
    input  logic                  iClk,
    input  logic                  iReset,
    input  logic                  iEnable,
    input  logic                  iClear,
    input  logic                  iUp_down,
    input  logic [1:0]            iMode,
    input  logic [WIDTH-1:0]      iStep,
    input  logic [WIDTH-1:0]      iMin,
    input  logic [WIDTH-1:0]      iMax,
    input  logic [WIDTH-1:0]      iInitialValue,
    input  logic [PRESCALE_W-1:0] iPrescale,
    output logic [WIDTH-1:0]      oData,
    output logic                  oDir,
    output logic                  oWrap,
    output logic                  oDone,
    output logic                  oAtMax,
    output logic                  oAtMin
);

    typedef enum logic [1:0] {
        MODE_WRAP    = 2'b00,
        MODE_SAT     = 2'b01,
        MODE_ONESHOT = 2'b10,
        MODE_BOUNCE  = 2'b11
    } mode_e;

    logic [WIDTH-1:0]      data_q, data_d;
    logic                  dir_q, dir_d;
    logic                  wrap_q, wrap_d;
    logic                  done_q, done_d;
    logic [PRESCALE_W-1:0] pre_q, pre_d;

    mode_e            mode;
    logic             tick;
    logic             dir_eff;
    logic             fire;
    logic [WIDTH:0]   sum_up;
    logic [WIDTH:0]   floor_dn;
    logic [WIDTH-1:0] bound;

    assign mode = mode_e'(iMode);

    always_comb begin
        tick     = iEnable && (pre_q == iPrescale);
        pre_d    = pre_q;
        if (iEnable) begin
            pre_d = tick ? '0 : pre_q + PRESCALE_W'(1);
        end

        dir_eff  = (mode == MODE_BOUNCE) ? dir_q : iUp_down;
        // Both bound tests are done one bit wider so a large step cannot alias past the bound.
        sum_up   = {1'b0, data_q} + {1'b0, iStep};
        floor_dn = {1'b0, iMin} + {1'b0, iStep};
        fire     = dir_eff ? (sum_up > {1'b0, iMax}) : ({1'b0, data_q} < floor_dn);
        bound    = dir_eff ? iMax : iMin;

        data_d = data_q;
        dir_d  = dir_eff;
        wrap_d = 1'b0;
        done_d = done_q;

        if (tick && !done_q && (iMin <= iMax)) begin
            if (fire) begin
                wrap_d = 1'b1;
                case (mode)
                    MODE_WRAP:    data_d = dir_eff ? iMin : iMax;
                    MODE_SAT:     data_d = bound;
                    MODE_ONESHOT: begin
                        data_d = bound;
                        done_d = 1'b1;
                    end
                    MODE_BOUNCE:  begin
                        data_d = bound;
                        dir_d  = ~dir_q;
                    end
                endcase
            end else begin
                data_d = dir_eff ? sum_up[WIDTH-1:0] : (data_q - iStep);
            end
        end
    end

    always_ff @(posedge iClk) begin
        if (iReset) begin
            data_q <= '0;
            dir_q  <= 1'b1;
            wrap_q <= 1'b0;
            done_q <= 1'b0;
            pre_q  <= '0;
        end else if (iClear) begin
            data_q <= iInitialValue;
            dir_q  <= iUp_down;
            wrap_q <= 1'b0;
            done_q <= 1'b0;
            pre_q  <= '0;
        end else begin
            data_q <= data_d;
            dir_q  <= dir_d;
            wrap_q <= wrap_d;
            done_q <= done_d;
            pre_q  <= pre_d;
        end
    end

    assign oData  = data_q;
    assign oDir   = dir_q;
    assign oWrap  = wrap_q;
    assign oDone  = done_q;
    assign oAtMax = (data_q == iMax);
    assign oAtMin = (data_q == iMin);

endmodule
